// File: rtl/ase_pcie_ss_cpl_splitter.sv
// rtl/ase_pcie_ss_cpl_splitter.sv - splits DMA read requests into completion chunks bounded by RCB and max payload
module ase_pcie_ss_cpl_splitter #(
    parameter int MAX_PAYLOAD_BYTES = 256,
    parameter int RCB_BYTES         = 64,
    parameter int MAX_OUTSTANDING   = 256,
    parameter int REQ_FIFO_DEPTH    = 4,
    localparam int TAG_W            = $clog2(MAX_OUTSTANDING)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [63:0]      req_addr,
    input  logic [12:0]      req_len,
    output logic             cpl_valid,
    input  logic             cpl_ready,
    output logic [TAG_W-1:0] cpl_tag,
    output logic [63:0]      cpl_addr,
    output logic [12:0]      cpl_len,
    output logic [12:0]      cpl_byte_count,
    output logic             cpl_last,
    output logic             err_valid,
    output logic [TAG_W-1:0] err_tag,
    output logic [1:0]       err_code,
    output logic [TAG_W:0]   outstanding
);

    localparam int PTR_W   = $clog2(REQ_FIFO_DEPTH);
    localparam int RCB_LOG = $clog2(RCB_BYTES);
    localparam int ENT_W   = TAG_W + 64 + 13;

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t                 state;
    logic                   live;
    logic [ENT_W-1:0]       fifo_mem [REQ_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         fifo_cnt;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [MAX_OUTSTANDING-1:0] busy;

    logic                   accept;
    logic                   tag_oor;
    logic                   tag_busy;
    logic                   len_bad;
    logic                   pass;
    logic                   free;
    logic                   pop;
    logic [1:0]             err_code_d;

    logic [TAG_W-1:0]       head_tag;
    logic [63:0]            head_addr;
    logic [12:0]            head_len;
    logic [12:0]            head_chunk;
    logic [63:0]            next_addr;
    logic [12:0]            next_rem;
    logic [12:0]            next_chunk;

    // Largest chunk allowed from an address offset within the RCB: an
    // unaligned start is shortened so the following chunk lands on an RCB boundary.
    function automatic logic [12:0] chunk_of(input logic [RCB_LOG-1:0] off, input logic [12:0] rem);
        logic [31:0] limit;
        limit = 32'(MAX_PAYLOAD_BYTES) - 32'(off);
        return ({19'd0, rem} < limit) ? rem : limit[12:0];
    endfunction

    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(REQ_FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign req_ready  = live && !fifo_full;
    assign accept     = req_valid && req_ready;

    assign free     = cpl_valid && cpl_ready && cpl_last;
    assign tag_oor  = ({1'b0, req_tag} >= (TAG_W+1)'(MAX_OUTSTANDING));
    // A tag being released this very cycle counts as free for the new request.
    assign tag_busy = busy[req_tag] && !(free && (cpl_tag == req_tag));
    assign len_bad  = (req_len == 13'd0) || (req_len > 13'd4096) || (req_len[1:0] != 2'b00);
    assign pass     = accept && !tag_oor && !tag_busy && !len_bad;
    assign pop      = (state == IDLE) && !fifo_empty;

    assign {head_tag, head_addr, head_len} = fifo_mem[rd_ptr];
    assign head_chunk = chunk_of(head_addr[RCB_LOG-1:0], head_len);
    assign next_addr  = cpl_addr + {51'd0, cpl_len};
    assign next_rem   = cpl_byte_count - cpl_len;
    assign next_chunk = chunk_of(next_addr[RCB_LOG-1:0], next_rem);

    // Rejection reason in priority order: range, collision, length.
    always_comb begin
        err_code_d = 2'd0;
        if (tag_oor)
            err_code_d = 2'd1;
        else if (tag_busy)
            err_code_d = 2'd2;
        else if (len_bad)
            err_code_d = 2'd3;
    end

    // Holds req_ready low through reset and raises it on the first active cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)
            live <= 1'b0;
        else
            live <= 1'b1;
    end

    // Request queue storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (pass)
            fifo_mem[wr_ptr] <= {req_tag, req_addr, req_len};
    end

    // Request queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (pass)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (pass && !pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (!pass && pop)
                fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Tag scoreboard and in-flight count; a release and a reuse of the same tag leave it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy        <= '0;
            outstanding <= '0;
        end else begin
            if (free)
                busy[cpl_tag] <= 1'b0;
            if (pass)
                busy[req_tag] <= 1'b1;
            if (pass && !free)
                outstanding <= outstanding + 1'b1;
            else if (free && !pass)
                outstanding <= outstanding - 1'b1;
        end
    end

    // One-cycle report for each consumed request that failed its checks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_tag   <= '0;
            err_code  <= 2'd0;
        end else begin
            err_valid <= accept && !pass;
            if (accept && !pass) begin
                err_tag  <= req_tag;
                err_code <= err_code_d;
            end
        end
    end

    // Splitter: load a request, then walk it chunk by chunk with registered descriptors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cpl_valid      <= 1'b0;
            cpl_tag        <= '0;
            cpl_addr       <= '0;
            cpl_len        <= '0;
            cpl_byte_count <= '0;
            cpl_last       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cpl_tag        <= head_tag;
                        cpl_addr       <= head_addr;
                        cpl_byte_count <= head_len;
                        cpl_len        <= head_chunk;
                        cpl_last       <= (head_chunk == head_len);
                        cpl_valid      <= 1'b1;
                        state          <= SPLIT;
                    end
                end
                SPLIT: begin
                    if (cpl_ready) begin
                        if (cpl_last) begin
                            cpl_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            cpl_addr       <= next_addr;
                            cpl_byte_count <= next_rem;
                            cpl_len        <= next_chunk;
                            cpl_last       <= (next_chunk == next_rem);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
